// File: rtl/hsem_ahb_arb_pkg.sv
// Shared AHB widths, transfer/response codes and slave-side FSM encoding
// for the two-master semaphore arbiter.
package hsem_ahb_arb_pkg;

  localparam int AHB_DATA_WIDTH = 32;
  localparam int AHB_ADDR_WIDTH = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ADDR = 2'b01,
    S_DATA = 2'b10
  } slv_state_e;

  typedef struct packed {
    logic [AHB_ADDR_WIDTH-1:0] addr;
    logic                      write;
    logic [2:0]                size;
    logic [3:0]                prot;
    logic                      mastlock;
  } ahb_addr_t;

endpackage

// File: rtl/hsem_arb_port.sv
// Per-master capture stage: latches one address phase and stalls the master
// until the slave finishes that transfer.
module hsem_arb_port
  import hsem_ahb_arb_pkg::*;
(
  input  logic       hclk,
  input  logic       hresetn,
  input  logic [1:0] htrans,
  input  ahb_addr_t  addr_phase,
  input  logic       done,
  output logic       hready,
  output logic       pending,
  output logic       pending_nxt,
  output ahb_addr_t  held
);

  logic capture;

  // Completion reopens the port in the same cycle so a master can pipeline
  // its next address onto the last data cycle of the previous transfer.
  assign hready      = ~pending | done;
  assign capture     = hready & ((htrans == HTRANS_NONSEQ) | (htrans == HTRANS_SEQ));
  assign pending_nxt = capture | (pending & ~done);

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      pending <= 1'b0;
    end else begin
      pending <= pending_nxt;
    end
  end

  always_ff @(posedge hclk) begin
    if (capture) begin
      held <= addr_phase;
    end
  end

endmodule

// File: rtl/hsem_ahb_arb.sv
// Two-master to one-slave AHB arbiter in front of the hardware semaphore:
// round-robin grant with bus lock, one transfer in flight at a time.
module hsem_ahb_arb
  import hsem_ahb_arb_pkg::*;
(
  input  logic                      hclk,
  input  logic                      hresetn,
  input  logic [1:0]                m0_htrans,
  input  logic [AHB_ADDR_WIDTH-1:0] m0_haddr,
  input  logic                      m0_hwrite,
  input  logic [2:0]                m0_hsize,
  input  logic [3:0]                m0_hprot,
  input  logic                      m0_hmastlock,
  input  logic [AHB_DATA_WIDTH-1:0] m0_hwdata,
  output logic                      m0_hready,
  output logic [1:0]                m0_hresp,
  output logic [AHB_DATA_WIDTH-1:0] m0_hrdata,
  input  logic [1:0]                m1_htrans,
  input  logic [AHB_ADDR_WIDTH-1:0] m1_haddr,
  input  logic                      m1_hwrite,
  input  logic [2:0]                m1_hsize,
  input  logic [3:0]                m1_hprot,
  input  logic                      m1_hmastlock,
  input  logic [AHB_DATA_WIDTH-1:0] m1_hwdata,
  output logic                      m1_hready,
  output logic [1:0]                m1_hresp,
  output logic [AHB_DATA_WIDTH-1:0] m1_hrdata,
  output logic                      s_hsel,
  output logic [1:0]                s_htrans,
  output logic [AHB_ADDR_WIDTH-1:0] s_haddr,
  output logic                      s_hwrite,
  output logic [2:0]                s_hsize,
  output logic [3:0]                s_hprot,
  output logic                      s_hmastlock,
  output logic [AHB_DATA_WIDTH-1:0] s_hwdata,
  output logic                      s_hready,
  output logic                      s_hmaster,
  input  logic                      s_hreadyout,
  input  logic [1:0]                s_hresp,
  input  logic [AHB_DATA_WIDTH-1:0] s_hrdata
);

  slv_state_e state, state_nxt;
  logic       grant, last_grant, lock_act;
  logic       go, pick, take;
  logic [1:0] pend, req_nxt, done;
  ahb_addr_t  m0_ap, m1_ap, held0, held1, cur_held;

  assign m0_ap = '{addr: m0_haddr, write: m0_hwrite, size: m0_hsize,
                   prot: m0_hprot, mastlock: m0_hmastlock};
  assign m1_ap = '{addr: m1_haddr, write: m1_hwrite, size: m1_hsize,
                   prot: m1_hprot, mastlock: m1_hmastlock};

  assign done[0]  = (state == S_DATA) && !grant && s_hreadyout;
  assign done[1]  = (state == S_DATA) &&  grant && s_hreadyout;
  assign cur_held = grant ? held1 : held0;

  hsem_arb_port u_port0 (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .htrans      (m0_htrans),
    .addr_phase  (m0_ap),
    .done        (done[0]),
    .hready      (m0_hready),
    .pending     (pend[0]),
    .pending_nxt (req_nxt[0]),
    .held        (held0)
  );

  hsem_arb_port u_port1 (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .htrans      (m1_htrans),
    .addr_phase  (m1_ap),
    .done        (done[1]),
    .hready      (m1_hready),
    .pending     (pend[1]),
    .pending_nxt (req_nxt[1]),
    .held        (held1)
  );

  // Arbitration looks at next-cycle pending so a same-cycle capture is seen;
  // while locked, only the lock owner can be granted.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    pick      = last_grant;
    go        = lock_act ? req_nxt[last_grant] : |req_nxt;
    if (!lock_act) begin
      pick = (req_nxt == 2'b11) ? ~last_grant : req_nxt[1];
    end
    case (state)
      S_IDLE: if (go) begin
        state_nxt = S_ADDR;
        take      = 1'b1;
      end
      S_ADDR: state_nxt = S_DATA;
      S_DATA: if (s_hreadyout) begin
        state_nxt = go ? S_ADDR : S_IDLE;
        take      = go;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state      <= S_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      lock_act   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        grant      <= pick;
        last_grant <= pick;
      end
      if (state == S_ADDR) begin
        lock_act <= cur_held.mastlock;
      end
    end
  end

  always_comb begin
    s_hsel      = 1'b0;
    s_htrans    = HTRANS_IDLE;
    s_haddr     = '0;
    s_hwrite    = 1'b0;
    s_hsize     = '0;
    s_hprot     = '0;
    s_hmastlock = 1'b0;
    s_hwdata    = '0;
    s_hready    = 1'b1;
    s_hmaster   = 1'b0;
    m0_hresp    = HRESP_OKAY;
    m1_hresp    = HRESP_OKAY;
    m0_hrdata   = '0;
    m1_hrdata   = '0;
    case (state)
      S_ADDR: begin
        s_hsel      = 1'b1;
        s_htrans    = HTRANS_NONSEQ;
        s_haddr     = cur_held.addr;
        s_hwrite    = cur_held.write;
        s_hsize     = cur_held.size;
        s_hprot     = cur_held.prot;
        s_hmastlock = cur_held.mastlock;
        s_hmaster   = grant;
      end
      S_DATA: begin
        s_hmaster = grant;
        s_hwdata  = grant ? m1_hwdata : m0_hwdata;
        s_hready  = s_hreadyout;
        if (grant) begin
          m1_hresp  = s_hresp;
          m1_hrdata = s_hrdata;
        end else begin
          m0_hresp  = s_hresp;
          m0_hrdata = s_hrdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hsem_ahb_arb.sv
// Randomized bench for hsem_ahb_arb: a transaction-slot reference model
// predicts every master- and slave-side output each cycle.
module tb_hsem_ahb_arb;

  logic        hclk, hresetn;
  logic [1:0]  m_htrans [2];
  logic [31:0] m_haddr  [2];
  logic        m_hwrite [2];
  logic [2:0]  m_hsize  [2];
  logic [3:0]  m_hprot  [2];
  logic        m_hlock  [2];
  logic [31:0] m_hwdata [2];
  logic        m0_hready, m1_hready;
  logic [1:0]  m0_hresp, m1_hresp;
  logic [31:0] m0_hrdata, m1_hrdata;
  logic        s_hsel, s_hwrite, s_hmastlock, s_hready, s_hmaster, s_hreadyout;
  logic [1:0]  s_htrans, s_hresp;
  logic [31:0] s_haddr, s_hwdata, s_hrdata;
  logic [2:0]  s_hsize;
  logic [3:0]  s_hprot;

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  hsem_ahb_arb dut (
    .hclk(hclk), .hresetn(hresetn),
    .m0_htrans(m_htrans[0]), .m0_haddr(m_haddr[0]), .m0_hwrite(m_hwrite[0]),
    .m0_hsize(m_hsize[0]), .m0_hprot(m_hprot[0]), .m0_hmastlock(m_hlock[0]),
    .m0_hwdata(m_hwdata[0]), .m0_hready(m0_hready), .m0_hresp(m0_hresp),
    .m0_hrdata(m0_hrdata),
    .m1_htrans(m_htrans[1]), .m1_haddr(m_haddr[1]), .m1_hwrite(m_hwrite[1]),
    .m1_hsize(m_hsize[1]), .m1_hprot(m_hprot[1]), .m1_hmastlock(m_hlock[1]),
    .m1_hwdata(m_hwdata[1]), .m1_hready(m1_hready), .m1_hresp(m1_hresp),
    .m1_hrdata(m1_hrdata),
    .s_hsel(s_hsel), .s_htrans(s_htrans), .s_haddr(s_haddr), .s_hwrite(s_hwrite),
    .s_hsize(s_hsize), .s_hprot(s_hprot), .s_hmastlock(s_hmastlock),
    .s_hwdata(s_hwdata), .s_hready(s_hready), .s_hmaster(s_hmaster),
    .s_hreadyout(s_hreadyout), .s_hresp(s_hresp), .s_hrdata(s_hrdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [3:0]  prot;
    logic        lock;
  } xfer_t;

  // Reference: each master owns at most one waiting transfer; the slave bus is
  // a single slot that a transfer occupies for an address then a data phase.
  bit    want   [2];
  xfer_t req    [2];
  int    owner;
  int    slot;      // 0 free, 1 address phase, 2 data phase
  int    last_won;
  bit    locked;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int winner(bit r0, bit r1);
    if (locked) begin
      if (last_won == 0) return r0 ? 0 : -1;
      return r1 ? 1 : -1;
    end
    if (r0 && r1) return 1 - last_won;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  function automatic void model_reset();
    want[0] = 0; want[1] = 0;
    owner = 0; slot = 0; last_won = 1; locked = 0;
  endfunction

  task automatic eval_cycle();
    bit          rdy [2];
    bit          fin [2];
    bit          cap [2];
    logic [12:0] ctl;
    logic [31:0] addr_e, wd_e;
    logic [1:0]  resp_e [2];
    logic [31:0] rd_e   [2];
    int          w;
    @(negedge hclk);
    for (int n = 0; n < 2; n++) begin
      bool_owner: begin end
      if (slot == 2 && owner == n) begin
        rdy[n] = s_hreadyout; resp_e[n] = s_hresp; rd_e[n] = s_hrdata;
      end else begin
        rdy[n] = !want[n]; resp_e[n] = 2'b00; rd_e[n] = 32'h0;
      end
    end
    ctl = 13'h0; addr_e = 32'h0; wd_e = 32'h0;
    if (slot == 1)
      ctl = {1'b1, 2'b10, req[owner].wr, req[owner].size, req[owner].prot,
             req[owner].lock, 1'(owner)};
    else if (slot == 2)
      ctl = {12'h0, 1'(owner)};
    if (slot == 1) addr_e = req[owner].addr;
    if (slot == 2) wd_e = m_hwdata[owner];
    chk("m_hready", {m1_hready, m0_hready}, {rdy[1], rdy[0]});
    chk("m_hresp", {m1_hresp, m0_hresp}, {resp_e[1], resp_e[0]});
    chk("m0_hrdata", m0_hrdata, rd_e[0]);
    chk("m1_hrdata", m1_hrdata, rd_e[1]);
    chk("s_ctl", {s_hsel, s_htrans, s_hwrite, s_hsize, s_hprot, s_hmastlock, s_hmaster}, ctl);
    chk("s_haddr", s_haddr, addr_e);
    chk("s_hwdata", s_hwdata, wd_e);
    chk("s_hready", s_hready, (slot == 2) ? s_hreadyout : 1'b1);
    if (!hresetn) begin
      model_reset();
      return;
    end
    for (int n = 0; n < 2; n++) begin
      fin[n] = (slot == 2 && owner == n && s_hreadyout);
      cap[n] = rdy[n] && m_htrans[n][1];
    end
    if (slot == 1) locked = req[owner].lock;
    for (int n = 0; n < 2; n++) begin
      if (cap[n]) begin
        want[n] = 1;
        req[n] = '{addr: m_haddr[n], wr: m_hwrite[n], size: m_hsize[n],
                   prot: m_hprot[n], lock: m_hlock[n]};
      end else if (fin[n]) begin
        want[n] = 0;
      end
    end
    if (slot == 1) begin
      slot = 2;
    end else if (slot == 0 || (slot == 2 && s_hreadyout)) begin
      w = winner(want[0], want[1]);
      if (w >= 0) begin
        owner = w; last_won = w; slot = 1;
      end else begin
        slot = 0;
      end
    end
  endtask

  task automatic rand_inputs(input int dens, input int lockp, input int waitp,
                             input int errp, input int rstp);
    for (int n = 0; n < 2; n++) begin
      if ($urandom_range(99) < dens) m_htrans[n] = 2'($urandom_range(3, 2));
      else                           m_htrans[n] = 2'($urandom_range(1, 0));
      m_haddr[n]  = {$urandom_range(15), 2'b00} | (($urandom_range(7) == 0) ? $urandom : 32'h0);
      m_hwrite[n] = 1'($urandom);
      m_hsize[n]  = 3'($urandom_range(2));
      m_hprot[n]  = 4'($urandom);
      m_hlock[n]  = ($urandom_range(99) < lockp);
      m_hwdata[n] = $urandom;
    end
    s_hreadyout = ($urandom_range(99) >= waitp);
    s_hresp     = ($urandom_range(99) < errp) ? 2'b01 : 2'b00;
    s_hrdata    = $urandom;
    hresetn     = ($urandom_range(999) >= rstp);
  endtask

  task automatic idle_inputs();
    for (int n = 0; n < 2; n++) begin
      m_htrans[n] = 2'b00; m_haddr[n] = 32'h0; m_hwrite[n] = 0; m_hsize[n] = 3'd2;
      m_hprot[n] = 4'h0; m_hlock[n] = 0; m_hwdata[n] = 32'h0;
    end
    s_hreadyout = 1; s_hresp = 2'b00; s_hrdata = 32'h0;
  endtask

  initial begin
    model_reset();
    idle_inputs();
    hresetn = 0;
    m_htrans[0] = 2'b10;
    // reset must dominate an active request
    repeat (2) begin
      @(posedge hclk); #1;
      eval_cycle();
    end
    // m0 writes 0x04 with data 0x1, then both masters read 0x00 together
    @(posedge hclk); #1;
    idle_inputs(); hresetn = 1;
    m_htrans[0] = 2'b10; m_haddr[0] = 32'h4; m_hwrite[0] = 1;
    eval_cycle();
    @(posedge hclk); #1;
    m_htrans[0] = 2'b00; m_hwdata[0] = 32'h1;
    eval_cycle();
    repeat (3) begin
      @(posedge hclk); #1;
      idle_inputs();
      eval_cycle();
    end
    @(posedge hclk); #1;
    m_htrans[0] = 2'b10; m_htrans[1] = 2'b10;
    eval_cycle();
    @(posedge hclk); #1;
    idle_inputs();
    repeat (6) begin
      eval_cycle();
      @(posedge hclk); #1;
    end
    // light traffic, no stalls
    repeat (400) begin
      rand_inputs(30, 0, 0, 0, 0);
      eval_cycle();
      @(posedge hclk); #1;
    end
    // heavy contention with locks, wait states and errors
    repeat (1500) begin
      rand_inputs(80, 40, 30, 20, 5);
      eval_cycle();
      @(posedge hclk); #1;
    end
    repeat (1500) begin
      rand_inputs(60, 25, 55, 35, 15);
      eval_cycle();
      @(posedge hclk); #1;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
